// File: rtl/framebuf_reader_lenet.sv
// Streams the cropped frame-buffer image as a zero-padded OUT_W x OUT_H raster over valid/ready.
// Pad and image tokens take the same 1-cycle issue slot; a 2-entry FIFO absorbs downstream stalls.
`ifndef W_AFRAMEBUF
`define W_AFRAMEBUF 9
`endif
`ifndef W1
`define W1 7
`endif

module framebuf_reader_lenet #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PAD    = 2,
    parameter int INVERT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture_ready,
    output logic [`W_AFRAMEBUF:0]   aa_frame_buf,
    output logic                    cena_frame_buf,
    input  logic [`W1:0]            qa_frame_buf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [`W1:0]            out_pix,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    start_drop
);
    localparam int OUT_W = IMG_W + 2 * PAD;
    localparam int OUT_H = IMG_H + 2 * PAD;
    localparam int AW    = `W_AFRAMEBUF + 1;
    localparam int DW    = `W1 + 1;
    localparam int RW    = $clog2(OUT_H + 1);
    localparam int CW    = $clog2(OUT_W + 1);

    localparam logic [RW-1:0] ROW_LO   = RW'(PAD);
    localparam logic [RW-1:0] ROW_HI   = RW'(OUT_H - PAD);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);
    localparam logic [CW-1:0] COL_LO   = CW'(PAD);
    localparam logic [CW-1:0] COL_HI   = CW'(OUT_W - PAD);
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    generate
        if (IMG_W * IMG_H > (1 << AW)) begin : g_addr_chk
            $fatal(1, "framebuf_reader_lenet: IMG_W*IMG_H exceeds address range");
        end
    endgenerate

    logic [1:0]          state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [1:0]          count_q, count_d;
    logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                inflight_q, inflight_d, infl_slot_q, infl_slot_d;
    logic [1:0][DW-1:0]  pix_q, pix_d;
    logic [1:0][2:0]     flg_q, flg_d;
    logic                frame_done_q, frame_done_d, start_drop_q, start_drop_d;

    logic          issue, in_img, rd_en, push, pop, last_col, last_row;
    logic [DW-1:0] qa_px, head_pix;

    assign qa_px    = (INVERT != 0) ? ~qa_frame_buf : qa_frame_buf;
    assign issue    = (state_q == S_RUN) && (count_q != 2'd2);
    assign in_img   = (row_q >= ROW_LO) && (row_q < ROW_HI) && (col_q >= COL_LO) && (col_q < COL_HI);
    assign rd_en    = issue && in_img;
    assign push     = issue;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    // The entry still waiting on SRAM data is served straight from qa until it is captured.
    assign head_pix = (inflight_q && (infl_slot_q == rd_ptr_q)) ? qa_px : pix_q[rd_ptr_q];

    assign out_valid      = (count_q != 2'd0);
    assign pop            = out_valid && out_ready;
    assign out_pix        = out_valid ? head_pix : '0;
    assign out_sof        = out_valid && flg_q[rd_ptr_q][2];
    assign out_eol        = out_valid && flg_q[rd_ptr_q][1];
    assign out_eof        = out_valid && flg_q[rd_ptr_q][0];
    assign cena_frame_buf = ~rd_en;
    assign aa_frame_buf   = rd_en ? addr_q : '0;
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = frame_done_q;
    assign start_drop     = start_drop_q;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        addr_d       = addr_q;
        pix_d        = pix_q;
        flg_d        = flg_q;
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        inflight_d   = rd_en;
        infl_slot_d  = wr_ptr_q;
        frame_done_d = 1'b0;
        start_drop_d = capture_ready && (state_q != S_IDLE);

        if (inflight_q) pix_d[infl_slot_q] = qa_px;
        if (push) begin
            pix_d[wr_ptr_q] = '0;
            flg_d[wr_ptr_q] = {(row_q == '0) && (col_q == '0), last_col, last_col && last_row};
        end

        case (state_q)
            S_IDLE: if (capture_ready) begin
                state_d = S_RUN;
                row_d   = '0;
                col_d   = '0;
                addr_d  = '0;
            end
            S_RUN: if (issue) begin
                if (rd_en) addr_d = addr_q + AW'(1);
                if (last_col) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                    if (last_row) state_d = S_DRAIN;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_DRAIN: if (pop && flg_q[rd_ptr_q][0]) begin
                state_d      = S_IDLE;
                frame_done_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            inflight_q   <= 1'b0;
            infl_slot_q  <= 1'b0;
            pix_q        <= '0;
            flg_q        <= '0;
            frame_done_q <= 1'b0;
            start_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            infl_slot_q  <= infl_slot_d;
            pix_q        <= pix_d;
            flg_q        <= flg_d;
            frame_done_q <= frame_done_d;
            start_drop_q <= start_drop_d;
        end
    end
endmodule

// File: tb/tb_framebuf_reader_lenet.sv
// Randomized bench for framebuf_reader_lenet against a raster/padding reference model.
`timescale 1ns/1ps
module tb_framebuf_reader_lenet;
    localparam int IMG_W = 28, IMG_H = 28, PAD = 2;
    localparam int OUT_W = IMG_W + 2 * PAD, OUT_H = IMG_H + 2 * PAD, NPIX = OUT_W * OUT_H;
    localparam int I2_W = 4, I2_H = 3, P2 = 1;
    localparam int O2_W = I2_W + 2 * P2, O2_H = I2_H + 2 * P2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, capture_ready, cena, out_valid, out_ready, out_sof, out_eol, out_eof;
    logic       busy, frame_done, start_drop;
    logic [9:0] aa;
    logic [7:0] qa, out_pix;

    logic       cap2, cena2, vld2, rdy2, sof2, eol2, eof2, busy2, done2, drop2;
    logic [9:0] aa2;
    logic [7:0] qa2, pix2;

    logic [7:0] mem  [1024];
    logic [7:0] mem2 [16];

    int n_tests = 0, n_fail = 0;
    int idx, done_cyc, first_vld, cena_cnt;

    framebuf_reader_lenet u_dut (
        .clk(clk), .rst(rst), .capture_ready(capture_ready),
        .aa_frame_buf(aa), .cena_frame_buf(cena), .qa_frame_buf(qa),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .frame_done(frame_done), .start_drop(start_drop)
    );

    framebuf_reader_lenet #(.IMG_W(I2_W), .IMG_H(I2_H), .PAD(P2), .INVERT(1)) u_dut_inv (
        .clk(clk), .rst(rst), .capture_ready(cap2),
        .aa_frame_buf(aa2), .cena_frame_buf(cena2), .qa_frame_buf(qa2),
        .out_valid(vld2), .out_ready(rdy2), .out_pix(pix2),
        .out_sof(sof2), .out_eol(eol2), .out_eof(eof2),
        .busy(busy2), .frame_done(done2), .start_drop(drop2)
    );

    always @(posedge clk) begin
        if (!cena)  qa  <= mem[aa];
        if (!cena2) qa2 <= mem2[aa2[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cena"}, cena, 1);
        chk({tag, "_aa"}, aa, 0);
        chk({tag, "_vld"}, out_valid, 0);
        chk({tag, "_pix"}, out_pix, 0);
        chk({tag, "_flags"}, {out_sof, out_eol, out_eof}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done_drop"}, {frame_done, start_drop}, 0);
    endtask

    // One frame: pct = out_ready probability, drop_at = cycle of a stray capture_ready,
    // chain = fire capture_ready in the frame_done cycle, prestart = frame already triggered.
    task automatic run_frame(input int pct, input int drop_at, input bit chain,
                             input bit prestart, input int stop_idx);
        int k, r, c;
        bit eof_acc, stall_prev, pad;
        logic [7:0] prev_pix, exp_pix;
        logic [2:0] prev_flg, exp_flg;
        idx = 0; cena_cnt = 0; done_cyc = -1; first_vld = -1;
        eof_acc = 0; stall_prev = 0; prev_pix = '0; prev_flg = '0;
        k = prestart ? 1 : 0;
        while (k < 6000) begin
            @(posedge clk); #1;
            capture_ready = (k == 0 && !prestart) || (k == drop_at) || (eof_acc && chain);
            out_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (!cena) cena_cnt++;
            if (stall_prev) begin
                chk("stall_vld", out_valid, 1);
                chk("stall_pix", out_pix, prev_pix);
                chk("stall_flags", {out_sof, out_eol, out_eof}, prev_flg);
            end
            if (k == 1) chk("vld_cycle1", out_valid, 0);
            if (prestart && k == 1) chk("no_drop_on_chain", start_drop, 0);
            if (drop_at > 0 && k == drop_at + 1) chk("start_drop", start_drop, 1);
            if (out_valid && first_vld < 0) first_vld = k;
            if (out_valid && out_ready) begin
                if (idx >= NPIX) begin
                    chk("extra_pixel", idx, NPIX - 1);
                end else begin
                    r = idx / OUT_W; c = idx % OUT_W;
                    pad = (r < PAD) || (r >= OUT_H - PAD) || (c < PAD) || (c >= OUT_W - PAD);
                    exp_pix = pad ? 8'h00 : mem[(r - PAD) * IMG_W + (c - PAD)];
                    exp_flg = {idx == 0, c == OUT_W - 1, idx == NPIX - 1};
                    chk("pix", out_pix, exp_pix);
                    chk("flags", {out_sof, out_eol, out_eof}, exp_flg);
                end
                if (out_eof) eof_acc = 1;
                idx++;
            end
            stall_prev = out_valid && !out_ready;
            prev_pix = out_pix;
            prev_flg = {out_sof, out_eol, out_eof};
            if (frame_done) begin
                done_cyc = k;
                chk("busy_at_done", busy, 0);
                break;
            end
            if (stop_idx >= 0 && idx == stop_idx) break;
            k++;
        end
        if (stop_idx < 0 && done_cyc < 0) chk("frame_timeout", 0, 1);
        if (stop_idx < 0) chk("pix_count", idx, NPIX);
        chk("first_vld_cycle", first_vld, 2);
    endtask

    initial begin
        int j, r, c;
        bit pad, seen;
        rst = 1; capture_ready = 0; out_ready = 0; cap2 = 0; rdy2 = 1;
        for (int i = 0; i < 16; i++) mem2[i] = 8'h00;
        #2;
        check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1 rst = 0;

        // Test 1: incrementing memory, always ready
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        run_frame(100, -1, 0, 0, -1);
        chk("done_cycle", done_cyc, NPIX + 2);
        chk("reads_t1", cena_cnt, IMG_W * IMG_H);
        @(posedge clk); #1; @(negedge clk);
        chk("done_once", frame_done, 0);

        // Test 2: same memory, random stalls
        run_frame(50, -1, 0, 0, -1);
        chk("reads_t2", cena_cnt, IMG_W * IMG_H);

        // Test 3: stray capture_ready mid-frame, random contents
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        run_frame(70, 300, 0, 0, -1);

        // Test 4: back-to-back frames via capture_ready in the frame_done cycle
        run_frame(100, -1, 1, 0, -1);
        run_frame(100, -1, 0, 1, -1);

        // Test 5: asynchronous reset mid-frame while stalled
        run_frame(60, -1, 0, 0, 500);
        @(posedge clk); #1 out_ready = 0; capture_ready = 0;
        @(negedge clk);
        chk("pre_rst_vld", out_valid, 1);
        #1 rst = 1;
        #1 check_reset_outputs("async_rst");
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        run_frame(80, -1, 0, 0, -1);

        // Test 6: inverted small image, zero memory
        @(posedge clk); #1 cap2 = 1;
        @(posedge clk); #1 cap2 = 0;
        j = 0; seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (vld2) begin
                r = j / O2_W; c = j % O2_W;
                pad = (r < P2) || (r >= O2_H - P2) || (c < P2) || (c >= O2_W - P2);
                chk("inv_pix", pix2, pad ? 8'h00 : 8'hFF);
                chk("inv_eof", eof2, (j == O2_W * O2_H - 1) ? 1 : 0);
                j++;
            end
            if (done2) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        chk("inv_count", j, O2_W * O2_H);
        chk("inv_done", seen, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
